// File: rtl/cam_lookup_arbiter_if.sv
// Handshake bundle between the lookup arbiter, its two requesters and the session CAM.
// master = arbiter side, slave = requesters plus CAM side.
interface cam_lookup_arbiter_if;
    logic        rx_req_valid;
    logic        rx_req_ready;
    logic [95:0] rx_req_key;
    logic        tx_req_valid;
    logic        tx_req_ready;
    logic [95:0] tx_req_key;

    logic        rx_rsp_valid;
    logic        rx_rsp_ready;
    logic        rx_rsp_hit;
    logic [13:0] rx_rsp_sid;
    logic        tx_rsp_valid;
    logic        tx_rsp_ready;
    logic        tx_rsp_hit;
    logic [13:0] tx_rsp_sid;

    logic        cam_req_valid;
    logic        cam_req_ready;
    logic [97:0] cam_req_dout;
    logic        cam_rsp_valid;
    logic        cam_rsp_ready;
    logic [15:0] cam_rsp_din;

    modport master (
        input  rx_req_valid, rx_req_key, tx_req_valid, tx_req_key,
        input  rx_rsp_ready, tx_rsp_ready,
        input  cam_req_ready, cam_rsp_valid, cam_rsp_din,
        output rx_req_ready, tx_req_ready,
        output rx_rsp_valid, rx_rsp_hit, rx_rsp_sid,
        output tx_rsp_valid, tx_rsp_hit, tx_rsp_sid,
        output cam_req_valid, cam_req_dout, cam_rsp_ready
    );

    modport slave (
        output rx_req_valid, rx_req_key, tx_req_valid, tx_req_key,
        output rx_rsp_ready, tx_rsp_ready,
        output cam_req_ready, cam_rsp_valid, cam_rsp_din,
        input  rx_req_ready, tx_req_ready,
        input  rx_rsp_valid, rx_rsp_hit, rx_rsp_sid,
        input  tx_rsp_valid, tx_rsp_hit, tx_rsp_sid,
        input  cam_req_valid, cam_req_dout, cam_rsp_ready
    );
endinterface

// File: rtl/cam_lookup_arbiter.sv
// Round-robin sharing of the session-CAM lookup port between RX (src 0) and TX_APP (src 1).
// Define CAM_ARB_STATS_EN to add per-source hit/miss counters with a synchronous clear.
module cam_lookup_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cam_ready,
    cam_lookup_arbiter_if.master bus,
    output logic [CNT_W-1:0]     rx_outstanding,
    output logic [CNT_W-1:0]     tx_outstanding,
    output logic                 err_unexp_rsp
`ifdef CAM_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [31:0]          rx_hit_cnt,
    output logic [31:0]          rx_miss_cnt,
    output logic [31:0]          tx_hit_cnt,
    output logic [31:0]          tx_miss_cnt
`endif
);
    typedef enum logic {SRC_RX = 1'b0, SRC_TX = 1'b1} src_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    src_e        last_q, last_d;
    logic        slot_valid_q;
    logic [97:0] slot_data_q;
    logic        slot_free, rx_elig, tx_elig;
    logic        grant_rx, grant_tx;
    logic        rsp_src, rsp_fire;
    logic        rx_dec, tx_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= SRC_TX;
        else        last_q <= last_d;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch leaves it unassigned and no latch is inferred.
        grant_rx  = 1'b0;
        grant_tx  = 1'b0;
        last_d    = last_q;
        slot_free = !slot_valid_q || bus.cam_req_ready;
        rx_elig   = bus.rx_req_valid && (rx_outstanding < MAX_CNT) && cam_ready && slot_free;
        tx_elig   = bus.tx_req_valid && (tx_outstanding < MAX_CNT) && cam_ready && slot_free;
        if (rx_elig && (!tx_elig || last_q == SRC_TX)) begin
            grant_rx = 1'b1;
            last_d   = SRC_RX;
        end else if (tx_elig) begin
            grant_tx = 1'b1;
            last_d   = SRC_TX;
        end
    end

    assign bus.rx_req_ready  = grant_rx;
    assign bus.tx_req_ready  = grant_tx;
    assign bus.cam_req_valid = slot_valid_q;
    assign bus.cam_req_dout  = slot_data_q;

    // Responses are steered purely by the source bit the CAM echoes back.
    assign rsp_src           = bus.cam_rsp_din[0];
    assign bus.rx_rsp_valid  = bus.cam_rsp_valid && !rsp_src;
    assign bus.tx_rsp_valid  = bus.cam_rsp_valid && rsp_src;
    assign bus.rx_rsp_hit    = bus.cam_rsp_din[15];
    assign bus.tx_rsp_hit    = bus.cam_rsp_din[15];
    assign bus.rx_rsp_sid    = bus.cam_rsp_din[14:1];
    assign bus.tx_rsp_sid    = bus.cam_rsp_din[14:1];
    assign bus.cam_rsp_ready = rsp_src ? bus.tx_rsp_ready : bus.rx_rsp_ready;

    assign rsp_fire = bus.cam_rsp_valid && bus.cam_rsp_ready;
    assign rx_dec   = rsp_fire && !rsp_src;
    assign tx_dec   = rsp_fire && rsp_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q   <= 1'b0;
            slot_data_q    <= '0;
            rx_outstanding <= '0;
            tx_outstanding <= '0;
            err_unexp_rsp  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so each one samples the pre-edge values of the others.
            if (grant_rx || grant_tx) begin
                slot_valid_q <= 1'b1;
                slot_data_q  <= {1'b0, (grant_tx ? bus.tx_req_key : bus.rx_req_key), grant_tx};
            end else if (bus.cam_req_ready) begin
                slot_valid_q <= 1'b0;
            end

            if (grant_rx && !rx_dec)
                rx_outstanding <= rx_outstanding + CNT_W'(1);
            else if (rx_dec && !grant_rx && rx_outstanding != '0)
                rx_outstanding <= rx_outstanding - CNT_W'(1);

            if (grant_tx && !tx_dec)
                tx_outstanding <= tx_outstanding + CNT_W'(1);
            else if (tx_dec && !grant_tx && tx_outstanding != '0)
                tx_outstanding <= tx_outstanding - CNT_W'(1);

            // A response with nothing in flight for its source is a CAM or integration bug.
            if ((rx_dec && !grant_rx && rx_outstanding == '0) ||
                (tx_dec && !grant_tx && tx_outstanding == '0))
                err_unexp_rsp <= 1'b1;
        end
    end

`ifdef CAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || stats_clr) begin
            rx_hit_cnt  <= '0;
            rx_miss_cnt <= '0;
            tx_hit_cnt  <= '0;
            tx_miss_cnt <= '0;
        end else if (rsp_fire) begin
            case ({rsp_src, bus.cam_rsp_din[15]})
                2'b01:   rx_hit_cnt  <= rx_hit_cnt + 32'd1;
                2'b00:   rx_miss_cnt <= rx_miss_cnt + 32'd1;
                2'b11:   tx_hit_cnt  <= tx_hit_cnt + 32'd1;
                default: tx_miss_cnt <= tx_miss_cnt + 32'd1;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_cam_lookup_arbiter.sv
// Self-checking bench for cam_lookup_arbiter: directed scenarios with literal expectations plus
// a randomized phase compared every cycle against a queue-based behavioural model.
module tb_cam_lookup_arbiter;
    localparam int MAX_OUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cam_ready = 1'b0;
    logic [3:0] rx_outstanding, tx_outstanding;
    logic err_unexp_rsp;
`ifdef CAM_ARB_STATS_EN
    logic stats_clr = 1'b0;
    logic [31:0] rx_hit_cnt, rx_miss_cnt, tx_hit_cnt, tx_miss_cnt;
`endif

    cam_lookup_arbiter_if bus ();

    cam_lookup_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cam_ready      (cam_ready),
        .bus            (bus.master),
        .rx_outstanding (rx_outstanding),
        .tx_outstanding (tx_outstanding),
        .err_unexp_rsp  (err_unexp_rsp)
`ifdef CAM_ARB_STATS_EN
        ,
        .stats_clr      (stats_clr),
        .rx_hit_cnt     (rx_hit_cnt),
        .rx_miss_cnt    (rx_miss_cnt),
        .tx_hit_cnt     (tx_hit_cnt),
        .tx_miss_cnt    (tx_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the issue slot as a 0/1-entry queue, in-flight counts per source,
    // the source granted last, and a sticky error bit. cam_q lists sources the CAM still owes.
    logic [97:0] m_slot[$];
    bit          cam_q[$];
    int          m_out[2] = '{0, 0};
    int          m_last   = 1;
    bit          m_err    = 1'b0;

    function automatic int exp_grant();
        bit free;
        bit el[2];
        free  = (m_slot.size() == 0) || bus.cam_req_ready;
        el[0] = bus.rx_req_valid && (m_out[0] < MAX_OUT) && cam_ready && free;
        el[1] = bus.tx_req_valid && (m_out[1] < MAX_OUT) && cam_ready && free;
        if (el[0] && el[1]) return 1 - m_last;
        if (el[0]) return 0;
        if (el[1]) return 1;
        return -1;
    endfunction

    task automatic model_update();
        int g;
        bit src;
        bit rsp_hs;
        g      = exp_grant();
        src    = bus.cam_rsp_din[0];
        rsp_hs = bus.cam_rsp_valid && (src ? bus.tx_rsp_ready : bus.rx_rsp_ready);
        if (m_slot.size() != 0 && bus.cam_req_ready) begin
            cam_q.push_back(m_slot[0][0]);
            void'(m_slot.pop_front());
        end
        if (g >= 0) begin
            m_slot.push_back({1'b0, (g == 0) ? bus.rx_req_key : bus.tx_req_key, 1'(g)});
            m_last = g;
        end
        if (rsp_hs && cam_q.size() != 0) void'(cam_q.pop_front());
        for (int s = 0; s < 2; s++) begin
            bit inc, dec;
            inc = (g == s);
            dec = rsp_hs && (int'(src) == s);
            if (inc && !dec) m_out[s]++;
            else if (dec && !inc) begin
                if (m_out[s] == 0) m_err = 1'b1;
                else m_out[s]--;
            end
        end
    endtask

    task automatic model_reset();
        m_slot.delete();
        cam_q.delete();
        m_out  = '{0, 0};
        m_last = 1;
        m_err  = 1'b0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_update();
    end

    task automatic compare_cycle();
        int g;
        bit src;
        g   = exp_grant();
        src = bus.cam_rsp_din[0];
        check("rx_req_ready", bus.rx_req_ready, g == 0);
        check("tx_req_ready", bus.tx_req_ready, g == 1);
        check("cam_req_valid", bus.cam_req_valid, m_slot.size() != 0);
        if (m_slot.size() != 0) check("cam_req_dout", bus.cam_req_dout, m_slot[0]);
        check("rx_outstanding", rx_outstanding, m_out[0]);
        check("tx_outstanding", tx_outstanding, m_out[1]);
        check("err_unexp_rsp", err_unexp_rsp, m_err);
        check("rx_rsp_valid", bus.rx_rsp_valid, bus.cam_rsp_valid && !src);
        check("tx_rsp_valid", bus.tx_rsp_valid, bus.cam_rsp_valid && src);
        check("cam_rsp_ready", bus.cam_rsp_ready, src ? bus.tx_rsp_ready : bus.rx_rsp_ready);
        if (bus.cam_rsp_valid && !src) begin
            check("rx_rsp_hit", bus.rx_rsp_hit, bus.cam_rsp_din[15]);
            check("rx_rsp_sid", bus.rx_rsp_sid, bus.cam_rsp_din[14:1]);
        end
        if (bus.cam_rsp_valid && src) begin
            check("tx_rsp_hit", bus.tx_rsp_hit, bus.cam_rsp_din[15]);
            check("tx_rsp_sid", bus.tx_rsp_sid, bus.cam_rsp_din[14:1]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) compare_cycle();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rx_req_valid  = 1'b0;
        bus.tx_req_valid  = 1'b0;
        bus.rx_req_key    = '0;
        bus.tx_req_key    = '0;
        bus.rx_rsp_ready  = 1'b0;
        bus.tx_rsp_ready  = 1'b0;
        bus.cam_req_ready = 1'b0;
        bus.cam_rsp_valid = 1'b0;
        bus.cam_rsp_din   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [95:0] key_a, key_b;
        int grants;

        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst cam_req_valid", bus.cam_req_valid, 1'b0);
        check("rst cam_req_dout", bus.cam_req_dout, 98'd0);
        check("rst rx_outstanding", rx_outstanding, 4'd0);
        check("rst tx_outstanding", tx_outstanding, 4'd0);
        check("rst err", err_unexp_rsp, 1'b0);

        // Single RX lookup and its response
        key_a = 96'h0A000001_0A000002_1F90_C350;
        cam_ready = 1'b1;
        bus.cam_req_ready = 1'b1;
        bus.rx_req_valid  = 1'b1;
        bus.rx_req_key    = key_a;
        #1;
        check("single rx_req_ready", bus.rx_req_ready, 1'b1);
        check("single tx_req_ready", bus.tx_req_ready, 1'b0);
        tick();
        bus.rx_req_valid = 1'b0;
        check("single cam_req_valid", bus.cam_req_valid, 1'b1);
        check("single cam_req_dout", bus.cam_req_dout, {1'b0, 96'h0A000001_0A000002_1F90_C350, 1'b0});
        check("single rx_out=1", rx_outstanding, 4'd1);
        tick();
        bus.cam_rsp_valid = 1'b1;
        bus.cam_rsp_din   = {1'b1, 14'h1234, 1'b0};
        bus.rx_rsp_ready  = 1'b1;
        #1;
        check("single rx_rsp_valid", bus.rx_rsp_valid, 1'b1);
        check("single rx_rsp_hit", bus.rx_rsp_hit, 1'b1);
        check("single rx_rsp_sid", bus.rx_rsp_sid, 14'h1234);
        check("single tx_rsp_valid", bus.tx_rsp_valid, 1'b0);
        check("single cam_rsp_ready", bus.cam_rsp_ready, 1'b1);
        check("single slot drained", bus.cam_req_valid, 1'b0);
        tick();
        bus.cam_rsp_valid = 1'b0;
        check("single rx_out=0", rx_outstanding, 4'd0);

        // Both requesters continuously valid: strict alternation starting with RX
        do_reset();
        cam_ready = 1'b1;
        bus.cam_req_ready = 1'b1;
        bus.rx_req_valid  = 1'b1;
        bus.tx_req_valid  = 1'b1;
        bus.rx_req_key    = {$urandom, $urandom, $urandom};
        bus.tx_req_key    = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            #1;
            check("alt rx_req_ready", bus.rx_req_ready, (i % 2) == 0);
            check("alt tx_req_ready", bus.tx_req_ready, (i % 2) == 1);
            tick();
            check("alt cam_req_valid", bus.cam_req_valid, 1'b1);
            check("alt src bit", bus.cam_req_dout[0], (i % 2) == 1);
        end
        #1;
        check("alt full rx_req_ready", bus.rx_req_ready, 1'b0);
        check("alt full tx_req_ready", bus.tx_req_ready, 1'b0);
        check("alt rx_out=4", rx_outstanding, 4'd4);
        check("alt tx_out=4", tx_outstanding, 4'd4);

        // RX alone with responses withheld stops at the outstanding limit; TX is independent
        do_reset();
        cam_ready = 1'b1;
        bus.cam_req_ready = 1'b1;
        bus.rx_req_valid  = 1'b1;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.rx_req_ready) grants++;
            tick();
        end
        check("limit rx grants", grants, 4);
        check("limit rx_out=4", rx_outstanding, 4'd4);
        check("limit rx_req_ready", bus.rx_req_ready, 1'b0);
        bus.tx_req_valid = 1'b1;
        #1;
        check("limit tx granted", bus.tx_req_ready, 1'b1);
        tick();
        bus.tx_req_valid = 1'b0;
        bus.rx_req_valid = 1'b0;

        // CAM stalls with the slot full: contents hold, nothing new is accepted
        do_reset();
        key_a = {$urandom, $urandom, $urandom};
        key_b = ~key_a;
        cam_ready = 1'b1;
        bus.rx_req_valid = 1'b1;
        bus.rx_req_key   = key_a;
        tick();
        bus.rx_req_key = key_b;
        for (int i = 0; i < 5; i++) begin
            check("stall cam_req_valid", bus.cam_req_valid, 1'b1);
            check("stall cam_req_dout", bus.cam_req_dout, {1'b0, key_a, 1'b0});
            check("stall rx_req_ready", bus.rx_req_ready, 1'b0);
            tick();
        end
        bus.cam_req_ready = 1'b1;
        #1;
        check("b2b rx_req_ready", bus.rx_req_ready, 1'b1);
        tick();
        bus.rx_req_valid = 1'b0;
        check("b2b cam_req_valid", bus.cam_req_valid, 1'b1);
        check("b2b cam_req_dout", bus.cam_req_dout, {1'b0, key_b, 1'b0});

        // Response for TX with nothing outstanding
        do_reset();
        bus.cam_rsp_valid = 1'b1;
        bus.cam_rsp_din   = {1'b0, 14'h0005, 1'b1};
        bus.tx_rsp_ready  = 1'b1;
        #1;
        check("unexp tx_rsp_valid", bus.tx_rsp_valid, 1'b1);
        tick();
        bus.cam_rsp_valid = 1'b0;
        check("unexp err set", err_unexp_rsp, 1'b1);
        check("unexp tx_out=0", tx_outstanding, 4'd0);
        tick();
        tick();
        check("unexp err sticky", err_unexp_rsp, 1'b1);

        // Asynchronous reset with three RX lookups in flight
        do_reset();
        cam_ready = 1'b1;
        bus.cam_req_ready = 1'b1;
        bus.rx_req_valid  = 1'b1;
        bus.rx_req_key    = {$urandom, $urandom, $urandom};
        repeat (3) tick();
        bus.rx_req_valid = 1'b0;
        check("arst pre rx_out=3", rx_outstanding, 4'd3);
        check("arst pre cam_req_valid", bus.cam_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst cam_req_valid", bus.cam_req_valid, 1'b0);
        check("arst cam_req_dout", bus.cam_req_dout, 98'd0);
        check("arst rx_out", rx_outstanding, 4'd0);
        check("arst tx_out", tx_outstanding, 4'd0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic, CAM stub answers in order from the bench's own queue
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cam_ready         = ($urandom_range(0, 7) != 0);
            bus.rx_req_valid  = ($urandom_range(0, 3) != 0);
            bus.tx_req_valid  = ($urandom_range(0, 3) != 0);
            bus.rx_req_key    = {$urandom, $urandom, $urandom};
            bus.tx_req_key    = {$urandom, $urandom, $urandom};
            bus.cam_req_ready = ($urandom_range(0, 3) != 0);
            bus.rx_rsp_ready  = ($urandom_range(0, 3) != 0);
            bus.tx_rsp_ready  = ($urandom_range(0, 3) != 0);
            if (cam_q.size() != 0 && $urandom_range(0, 2) != 0) begin
                bus.cam_rsp_valid = 1'b1;
                bus.cam_rsp_din   = {1'($urandom), 14'($urandom), cam_q[0]};
            end else begin
                bus.cam_rsp_valid = 1'b0;
                bus.cam_rsp_din   = 16'($urandom);
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
